dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 128, data memory size in 32-bit words (power of two).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to resp_valid (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_rd_ctrl  input  3  load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU.
REQ-011 req_wr_ctrl  input  2  store type: 00 SW, 01 SH, 10 SB.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  initiator accepts the response.
REQ-014 resp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 resp_err  output  1  access rejected; only driven when DMEM_MISALIGN_CHECK_EN is defined, else tied 0.

Function
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 req_ready shall be 1 only in IDLE; a handshake is req_valid&&req_ready on a rising edge.
REQ-018 On handshake, latch all request fields, load the counter with LATENCY-1, and go to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-019 WAIT decrements the counter each cycle and goes to RESP when it reaches 0; resp_valid rises exactly LATENCY cycles after the handshake edge.
REQ-020 Stores commit to the array on the edge entering RESP; byte lanes: SB writes addr[1:0] lane, SH writes halfword addr[1], SW writes all four.
REQ-021 Loads sample the array on the edge entering RESP; LB/LH sign-extend and LBU/LHU zero-extend the selected lane; LW returns the word.
REQ-022 Word index = req_addr[log2(DEPTH)+1:2]; higher address bits are ignored (wrap-around).
REQ-023 In RESP, resp_valid and resp_rdata/resp_err stay stable until resp_ready=1; on that edge go to IDLE.
REQ-024 No back-to-back acceptance: req_ready shall be 0 in the cycle of the response handshake and 1 the following cycle.
REQ-025 req_valid during WAIT/RESP shall be ignored and not queued.
REQ-026 Undefined rd_ctrl (101..111) behaves as LW; wr_ctrl 11 behaves as SW.

Reset
REQ-027 While rst=0: state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
REQ-028 Reset asserted in WAIT aborts the request; an uncommitted store shall not modify the array.
REQ-029 Array contents are not reset.
REQ-030 req_ready rises in the first clk edge after rst deasserts.

Configuration
REQ-031 Macro DMEM_MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, complete with resp_err=1, resp_rdata=0, and no array write, with unchanged latency.
REQ-032 Macro undefined: low address bits below the access size are forced to 0 (natural alignment) and resp_err is constant 0.

Structure
REQ-033 The shared package dmem_pkg holds rd_ctrl/wr_ctrl encodings, the FSM state typedef, and the LATENCY range constants.
REQ-034 The sub-module dmem_lane_unit (combinational) computes the write byte-enable/merged data and the load extraction/extension.

Verification
REQ-035 SW 0xDEADBEEF @0x10, then LW @0x10, LATENCY=2 -> resp_valid 2 cycles after each handshake; LW returns 0xDEADBEEF.
REQ-036 SB 0x80 @0x13, then LB @0x13 and LBU @0x13 -> 0xFFFFFF80 and 0x00000080; word @0x10 = 0x80ADBEEF.
REQ-037 resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready 0, a second req_valid is ignored.
REQ-038 rst pulsed low in WAIT of SW 0x12345678 @0x20 -> outputs 0 immediately; a later LW @0x20 returns the prior value.
REQ-039 LW @0x22 with macro defined -> resp_err=1, rdata 0; without macro -> returns word @0x20.
REQ-040 DEPTH=128: SW 0xA5A5A5A5 @0x200, then LW @0x000 -> 0xA5A5A5A5 (wrap).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and latency limits for the
// data-memory responder.
package dmem_pkg;

    typedef enum logic [2:0] {
        RD_LW  = 3'b000,
        RD_LH  = 3'b001,
        RD_LHU = 3'b010,
        RD_LB  = 3'b011,
        RD_LBU = 3'b100
    } rd_ctrl_e;

    typedef enum logic [1:0] {
        WR_SW = 2'b00,
        WR_SH = 2'b01,
        WR_SB = 2'b10
    } wr_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    // Undefined encodings fall back to full-word accesses.
    function automatic size_e access_size(
        input logic       we,
        input logic [2:0] rd,
        input logic [1:0] wr
    );
        size_e s;
        s = SZ_WORD;
        if (we) begin
            case (wr)
                WR_SH:   s = SZ_HALF;
                WR_SB:   s = SZ_BYTE;
                default: s = SZ_WORD;
            endcase
        end else begin
            case (rd)
                RD_LH, RD_LHU: s = SZ_HALF;
                RD_LB, RD_LBU: s = SZ_BYTE;
                default:       s = SZ_WORD;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering for stores and load extraction/extension.
// DMEM_MISALIGN_CHECK_EN: flag misaligned accesses instead of aligning them.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  rd_ctrl,
    input  logic [1:0]  wr_ctrl,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        err
);

    size_e       size;
    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        size = access_size(we, rd_ctrl, wr_ctrl);
        err  = 1'b0;

        unique case (size)
            SZ_BYTE: off = addr_lo;
            SZ_HALF: off = {addr_lo[1], 1'b0};
            default: off = 2'b00;
        endcase

`ifdef DMEM_MISALIGN_CHECK_EN
        // Misaligned exactly when natural alignment would move the address.
        err = (off != addr_lo);
`endif

        unique case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << off;
                wword = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be    = 4'b0011 << off;
                wword = {2{wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = wdata;
            end
        endcase
        if (!we || err) be = 4'b0000;

        shifted = rword >> {off, 3'b000};
        case (rd_ctrl)
            RD_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
            RD_LBU:  rdata = {24'h0, shifted[7:0]};
            RD_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
            RD_LHU:  rdata = {16'h0, shifted[15:0]};
            default: rdata = shifted;
        endcase
        if (we || err) rdata = 32'h0;
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with valid/ready request/response.
// DMEM_MISALIGN_CHECK_EN enables resp_err for misaligned accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_rd_ctrl,
    input  logic [1:0]  req_wr_ctrl,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  rd_ctrl_q, rd_ctrl_d;
    logic [1:0]  wr_ctrl_q, wr_ctrl_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        hs;
    logic        enter_resp;
    logic        eff_we;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic [2:0]  eff_rd_ctrl;
    logic [1:0]  eff_wr_ctrl;
    logic [AW-1:0] idx;
    logic        unused_addr_bits;

    logic [3:0]  lane_be;
    logic [31:0] lane_wword;
    logic [31:0] lane_rdata;
    logic        lane_err;

    logic [31:0] mem [DEPTH];

    // With single-cycle latency the access happens on the handshake edge,
    // so the live request fields feed the lanes instead of the latches.
    always_comb begin
        if (LATENCY == 1) begin
            eff_we      = req_we;
            eff_addr    = req_addr;
            eff_wdata   = req_wdata;
            eff_rd_ctrl = req_rd_ctrl;
            eff_wr_ctrl = req_wr_ctrl;
        end else begin
            eff_we      = we_q;
            eff_addr    = addr_q;
            eff_wdata   = wdata_q;
            eff_rd_ctrl = rd_ctrl_q;
            eff_wr_ctrl = wr_ctrl_q;
        end
    end

    assign idx              = eff_addr[AW+1:2];
    assign unused_addr_bits = ^eff_addr[31:AW+2];

    dmem_lane_unit u_lane (
        .we      (eff_we),
        .addr_lo (eff_addr[1:0]),
        .rd_ctrl (eff_rd_ctrl),
        .wr_ctrl (eff_wr_ctrl),
        .wdata   (eff_wdata),
        .rword   (mem[idx]),
        .be      (lane_be),
        .wword   (lane_wword),
        .rdata   (lane_rdata),
        .err     (lane_err)
    );

    always_comb begin
        hs        = req_valid && req_ready_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_ctrl_d = rd_ctrl_q;
        wr_ctrl_d = wr_ctrl_q;

        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    we_d      = req_we;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    rd_ctrl_d = req_rd_ctrl;
                    wr_ctrl_d = req_wr_ctrl;
                    cnt_d     = 4'(LATENCY - 1);
                    state_d   = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        enter_resp   = (state_q != ST_RESP) && (state_d == ST_RESP);
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);

        if (enter_resp) begin
            resp_rdata_d = lane_rdata;
            resp_err_d   = lane_err;
        end else if (state_d == ST_RESP) begin
            resp_rdata_d = resp_rdata_q;
            resp_err_d   = resp_err_q;
        end else begin
            resp_rdata_d = 32'h0;
            resp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            rd_ctrl_q    <= 3'd0;
            wr_ctrl_q    <= 2'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_ctrl_q    <= rd_ctrl_d;
            wr_ctrl_q    <= wr_ctrl_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Array has no reset; state_q is forced to IDLE under reset, so an
    // aborted store can never reach the commit edge.
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be[b]) mem[idx][8*b +: 8] <= lane_wword[8*b +: 8];
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model.
// Honours DMEM_MISALIGN_CHECK_EN the same way the design does.
module tb_dmem_responder;

    localparam int DEPTH = 128;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_rd_ctrl = 3'd0;
    logic [1:0]  req_wr_ctrl = 2'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] ref_mem [DEPTH*4];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rd_ctrl (req_rd_ctrl),
        .req_wr_ctrl (req_wr_ctrl),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: a flat byte array with wrap-around byte addressing.
    task automatic model_xact(input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [2:0] rc,
                              input logic [1:0] wc,
                              output logic [31:0] erd, output logic eerr);
        int sz;
        int ba;
        logic [31:0] v;
        if (we) sz = (wc == 2'd1) ? 2 : (wc == 2'd2) ? 1 : 4;
        else    sz = (rc == 3'd1 || rc == 3'd2) ? 2 :
                     (rc == 3'd3 || rc == 3'd4) ? 1 : 4;
        ba   = int'(addr % (DEPTH * 4));
        eerr = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (ba % sz != 0) eerr = 1'b1;
`endif
        ba  = ba - (ba % sz);
        erd = 32'h0;
        if (!eerr) begin
            if (we) begin
                for (int k = 0; k < sz; k++) ref_mem[ba+k] = wd[8*k +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < sz; k++)
                    v = v | (32'(ref_mem[ba+k]) << (8 * k));
                if (rc == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
                if (rc == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                erd = v;
            end
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] rc,
                        input logic [1:0] wc, input int hold,
                        output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        req_valid   = 1'b1;
        req_we      = we;
        req_addr    = addr;
        req_wdata   = wd;
        req_rd_ctrl = rc;
        req_wr_ctrl = wc;
        resp_ready  = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!resp_valid && n < 40);
        chk("latency", n, LAT);
        @(negedge clk);
        rd = resp_rdata;
        er = resp_err;
        for (int i = 0; i < hold; i++) begin
            chk("hold_req_ready", req_ready, 0);
            req_valid   = 1'b1;
            req_we      = 1'b1;
            req_addr    = $urandom;
            req_wdata   = $urandom;
            req_wr_ctrl = 2'd0;
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_err", resp_err, er);
        end
        req_valid = 1'b0;
        chk("ready_at_resp_hs", req_ready, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("valid_drop", resp_valid, 0);
        chk("ready_after", req_ready, 1);
    endtask

    task automatic run(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] rc,
                       input logic [1:0] wc, input int hold,
                       output logic [31:0] rd_o, output logic er_o);
        logic [31:0] erd;
        logic        eerr;
        xact(we, addr, wd, rc, wc, hold, rd_o, er_o);
        model_xact(we, addr, wd, rc, wc, erd, eerr);
        chk("rdata", rd_o, erd);
        chk("err", er_o, eerr);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] prior;
        logic        er;
        int          n;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready, 1);

        for (int i = 0; i < DEPTH; i++)
            run(1'b1, 32'(i * 4), $urandom, 3'd0, 2'd0, 0, rd, er);

        run(1'b1, 32'h10, 32'hDEADBEEF, 3'd0, 2'd0, 0, rd, er);
        run(1'b0, 32'h10, 32'h0, 3'd0, 2'd0, 0, rd, er);
        chk("sw_lw", rd, 32'hDEADBEEF);

        run(1'b1, 32'h13, 32'h80, 3'd0, 2'd2, 0, rd, er);
        run(1'b0, 32'h13, 32'h0, 3'd3, 2'd0, 0, rd, er);
        chk("lb_sext", rd, 32'hFFFFFF80);
        run(1'b0, 32'h13, 32'h0, 3'd4, 2'd0, 0, rd, er);
        chk("lbu_zext", rd, 32'h00000080);
        run(1'b0, 32'h10, 32'h0, 3'd0, 2'd0, 5, rd, er);
        chk("word_after_sb", rd, 32'h80ADBEEF);

        run(1'b0, 32'h20, 32'h0, 3'd0, 2'd0, 0, prior, er);
        @(negedge clk);
        req_valid   = 1'b1;
        req_we      = 1'b1;
        req_addr    = 32'h20;
        req_wdata   = 32'h12345678;
        req_wr_ctrl = 2'd0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("abort_req_ready", req_ready, 0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_resp_rdata", resp_rdata, 0);
        chk("abort_resp_err", resp_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", req_ready, 1);
        run(1'b0, 32'h20, 32'h0, 3'd0, 2'd0, 0, rd, er);
        chk("aborted_store", rd, prior);

        run(1'b0, 32'h22, 32'h0, 3'd0, 2'd0, 0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("lw_misalign_err", er, 1);
        chk("lw_misalign_rdata", rd, 0);
`else
        chk("lw_aligned_down", rd, prior);
`endif

        run(1'b1, 32'h200, 32'hA5A5A5A5, 3'd0, 2'd0, 0, rd, er);
        run(1'b0, 32'h000, 32'h0, 3'd0, 2'd0, 0, rd, er);
        chk("wrap", rd, 32'hA5A5A5A5);

        for (int i = 0; i < 200; i++) begin
            run(1'($urandom_range(0, 1)), $urandom, $urandom,
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
